// File: rtl/skew_rd_ctrl_if.sv
// Handshake/bus bundle between a read-sequence requester and skew_rd_ctrl.
// master drives the command and stall; slave drives the memory read buses and status.
interface skew_rd_ctrl_if #(
    parameter int WIDTH_HEIGHT = 4,
    parameter int LEN_W        = 9
);
    logic                      start;
    logic [7:0]                base_addr;
    logic [LEN_W-1:0]          len;
    logic                      stall;
    logic [WIDTH_HEIGHT-1:0]   rd_en;
    logic [WIDTH_HEIGHT*8-1:0] rd_addr;
    logic [WIDTH_HEIGHT-1:0]   rd_valid;
    logic                      busy;
    logic                      done;

    modport master (
        output start, base_addr, len, stall,
        input  rd_en, rd_addr, rd_valid, busy, done
    );

    modport slave (
        input  start, base_addr, len, stall,
        output rd_en, rd_addr, rd_valid, busy, done
    );
endinterface

// File: rtl/skew_rd_ctrl.sv
// Diagonally skewed per-lane read sequencer for the systolic array input memories.
// Registered outputs: first reads one cycle after start, rd_valid one cycle after rd_en; stall freezes the walk and blanks reads.
module skew_rd_ctrl #(
    parameter int WIDTH_HEIGHT = 4,
    parameter int LEN_W        = 9
) (
    input  logic          clk,
    input  logic          reset,
    skew_rd_ctrl_if.slave bus
);
    localparam int CW = LEN_W + $clog2(WIDTH_HEIGHT);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state, state_nx;
    logic [CW-1:0]             c_q, c_nx;
    logic [7:0]                base_q, base_nx;
    logic [LEN_W-1:0]          len_q, len_nx;
    logic                      issue;
    logic                      done_nx;
    logic [CW-1:0]             last_c;
    logic [WIDTH_HEIGHT-1:0]   en_nx;
    logic [WIDTH_HEIGHT*8-1:0] addr_nx;

    // Index of the final diagonal step: len + lanes - 2.
    assign last_c = CW'(len_q) + CW'(WIDTH_HEIGHT - 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        c_nx     = c_q;
        base_nx  = base_q;
        len_nx   = len_q;
        issue    = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                // A start arriving while done is still showing belongs to the finished burst.
                if (bus.start && !bus.done) begin
                    if (bus.len != '0) begin
                        state_nx = RUN;
                        c_nx     = '0;
                        base_nx  = bus.base_addr;
                        len_nx   = bus.len;
                        issue    = 1'b1;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (c_q == last_c) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        c_nx  = c_q + CW'(1);
                        issue = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        en_nx   = '0;
        addr_nx = '0;
        for (int i = 0; i < WIDTH_HEIGHT; i++) begin
            if (issue && (c_nx >= CW'(i)) && (c_nx < CW'(i) + CW'(len_nx))) begin
                en_nx[i]        = 1'b1;
                addr_nx[8*i+:8] = base_nx + 8'(c_nx) - 8'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q          <= '0;
            base_q       <= '0;
            len_q        <= '0;
            bus.rd_en    <= '0;
            bus.rd_addr  <= '0;
            bus.rd_valid <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            c_q          <= c_nx;
            base_q       <= base_nx;
            len_q        <= len_nx;
            bus.rd_en    <= en_nx;
            bus.rd_addr  <= addr_nx;
            bus.rd_valid <= bus.rd_en;
            bus.busy     <= (state_nx == RUN);
            bus.done     <= done_nx;
        end
    end
endmodule

// File: tb/tb_skew_rd_ctrl.sv
// Scoreboard bench for skew_rd_ctrl: per-cycle expected bus values queued at command time.
module tb_skew_rd_ctrl;
    localparam int W = 4;

    typedef struct packed {
        logic [3:0]  en;
        logic [31:0] addr;
        logic [3:0]  vld;
        logic        busy;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    skew_rd_ctrl_if #(.WIDTH_HEIGHT(W), .LEN_W(9)) bus ();

    skew_rd_ctrl #(.WIDTH_HEIGHT(W), .LEN_W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Read step k of a burst: lane i reads base+k-i while i <= k < i+len.
    function automatic exp_t mk(input logic [7:0] b, input int l, input int k);
        exp_t e;
        e = '0;
        e.busy = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (k >= i && k < i + l) begin
                e.en[i] = 1'b1;
                e.addr[8*i+:8] = b + 8'(k - i);
            end
        end
        return e;
    endfunction

    task automatic cmp_entry(input string nm, input exp_t e);
        chk({nm, ".rd_en"}, 32'(bus.rd_en), 32'(e.en));
        chk({nm, ".rd_addr"}, bus.rd_addr, e.addr);
        chk({nm, ".rd_valid"}, 32'(bus.rd_valid), 32'(e.vld));
        chk({nm, ".busy"}, 32'(bus.busy), 32'(e.busy));
        chk({nm, ".done"}, 32'(bus.done), 32'(e.done));
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the cycle after done.
    task automatic run_burst(input string nm, input logic [7:0] b, input int l,
                             input int st_at, input int st_n, input int mid_at,
                             input bit start_in_done);
        exp_t q[$];
        exp_t e;
        int   n;
        if (l > 0) begin
            for (int k = 0; k <= l + W - 2; k++) begin
                q.push_back(mk(b, l, k));
                if (k == st_at) begin
                    e = '0;
                    e.busy = 1'b1;
                    for (int s = 0; s < st_n; s++) q.push_back(e);
                end
            end
        end
        e = '0;
        e.done = 1'b1;
        q.push_back(e);
        q.push_back('0);
        for (int j = 1; j < q.size(); j++) q[j].vld = q[j-1].en;

        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.len       = 9'(l);
        n = q.size();
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
            e = q.pop_front();
            cmp_entry(nm, e);
            bus.stall = (j >= st_at && j < st_at + st_n);
            if (j == mid_at) begin
                bus.start     = 1'b1;
                bus.base_addr = 8'h55;
                bus.len       = 9'd2;
            end
            if (start_in_done && e.done) begin
                bus.start     = 1'b1;
                bus.base_addr = 8'h33;
                bus.len       = 9'd3;
            end
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = 8'h00;
        bus.len       = 9'd0;
        bus.stall     = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst.rd_en", 32'(bus.rd_en), 32'h0);
        chk("rst.rd_addr", bus.rd_addr, 32'h0);
        chk("rst.rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst.busy", 32'(bus.busy), 32'h0);
        chk("rst.done", 32'(bus.done), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_burst("basic", 8'h10, 3, -1, 0, -1, 1'b0);
        run_burst("wrap", 8'hFE, 4, -1, 0, -1, 1'b0);
        run_burst("stall", 8'h00, 5, 2, 2, -1, 1'b0);
        run_burst("zero", 8'h30, 0, -1, 0, -1, 1'b0);
        run_burst("midstart", 8'h60, 6, -1, 0, 3, 1'b0);
        run_burst("donestart", 8'hA0, 3, -1, 0, -1, 1'b1);
        run_burst("b2b", 8'hB0, 2, -1, 0, -1, 1'b0);
        run_burst("stall_last", 8'hC0, 9, 11, 1, -1, 1'b0);

        // Abort a burst while lane 3 is mid-stream.
        bus.start     = 1'b1;
        bus.base_addr = 8'h20;
        bus.len       = 9'd5;
        repeat (4) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("abort.busy_before", 32'(bus.busy), 32'h1);
        chk("abort.rd_en_before", 32'(bus.rd_en), 32'hF);
        reset = 1'b1;
        #1;
        chk("abort.rd_en", 32'(bus.rd_en), 32'h0);
        chk("abort.rd_addr", bus.rd_addr, 32'h0);
        chk("abort.rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("abort.busy", 32'(bus.busy), 32'h0);
        chk("abort.done", 32'(bus.done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("post_abort.done", 32'(bus.done), 32'h0);
            chk("post_abort.busy", 32'(bus.busy), 32'h0);
            chk("post_abort.rd_en", 32'(bus.rd_en), 32'h0);
        end
        run_burst("after_rst", 8'h40, 4, -1, 0, -1, 1'b0);
        run_burst("long", 8'h80, 511, 100, 3, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
